// File: rtl/sb_cfg_pkg.sv
// Shared definitions for the switch-box configuration loader.
//   - DEF_WORD_W     : default bitstream / config word width
//   - OPC_MSB/OPC_LSB: opcode field position inside a header word
//   - OPC_WRITE/DONE : legal header opcodes
//   - ld_state_e     : loader FSM states
package sb_cfg_pkg;

    localparam int DEF_WORD_W = 32;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;

    localparam logic [7:0] OPC_WRITE = 8'h01;
    localparam logic [7:0] OPC_DONE  = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_STROBE = 2'd2,
        ST_FIN    = 2'd3
    } ld_state_e;

endpackage

// File: rtl/cfg_addr_decode.sv
// Tile address decoder (combinational).
//   addr   in   ADDR_W     tile address
//   en     in   1          decode enable; onehot is all-zero when low
//   onehot out  NUM_TILES  one-hot tile select, never set for an out-of-range address
//   oor    out  1          addr >= NUM_TILES (independent of en)
module cfg_addr_decode #(
    parameter int ADDR_W    = 8,
    parameter int NUM_TILES = 16
) (
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 en,
    output logic [NUM_TILES-1:0] onehot,
    output logic                 oor
);

    // Compare in a fixed 32-bit domain so NUM_TILES up to 256 works for any ADDR_W.
    logic [31:0] addr_ext;
    assign addr_ext = 32'(addr);
    assign oor      = (addr_ext >= 32'(NUM_TILES));

    for (genvar i = 0; i < NUM_TILES; i++) begin : g_sel
        assign onehot[i] = en && (addr_ext == 32'(i));
    end

endmodule

// File: rtl/sb_config_loader.sv
// Switch-box configuration loader. Decodes a valid/ready word stream of
// {header, payload} pairs into one-cycle per-tile config write strobes.
//   clk          in   1          fabric clock
//   reset        in   1          synchronous, active-high reset
//   bs_valid     in   1          bitstream word valid
//   bs_data      in   WORD_W     bitstream word
//   bs_ready     out  1          loader accepts a word this cycle
//   config_data  out  WORD_W     broadcast config word (holds last payload)
//   config_en    out  NUM_TILES  one-hot, single-cycle tile write strobe
//   config_done  out  1          DONE seen; sticky until reset
//   cfg_error    out  1          bad opcode / bad address seen; sticky until reset
//   write_count  out  16         successful tile writes, saturating
module sb_config_loader
    import sb_cfg_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_TILES = 16,
    parameter int ADDR_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bs_valid,
    input  logic [WORD_W-1:0]    bs_data,
    output logic                 bs_ready,
    output logic [WORD_W-1:0]    config_data,
    output logic [NUM_TILES-1:0] config_en,
    output logic                 config_done,
    output logic                 cfg_error,
    output logic [15:0]          write_count
);

    ld_state_e              state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic [NUM_TILES-1:0]   en_q, en_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [15:0]            wcnt_q, wcnt_d;

    logic                   accept;
    logic [7:0]             opcode;
    logic                   dec_en;
    logic [NUM_TILES-1:0]   dec_onehot;
    logic                   dec_oor;

    assign accept = bs_valid && ready_q;
    assign opcode = bs_data[OPC_MSB:OPC_LSB];

    cfg_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_TILES (NUM_TILES)
    ) u_dec (
        .addr   (addr_q),
        .en     (dec_en),
        .onehot (dec_onehot),
        .oor    (dec_oor)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        en_d    = '0;
        done_d  = done_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        dec_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (opcode == OPC_WRITE) begin
                        // Address is captured with the header; the payload word
                        // may arrive any number of cycles later.
                        addr_d  = bs_data[ADDR_W-1:0];
                        state_d = ST_DATA;
                    end else if (opcode == OPC_DONE) begin
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        // Illegal opcode: flag it and treat the next word as a header.
                        err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    data_d  = bs_data;
                    dec_en  = 1'b1;
                    en_d    = dec_onehot;  // all-zero for an out-of-range address
                    state_d = ST_STROBE;
                    if (dec_oor) begin
                        err_d = 1'b1;
                    end else if (wcnt_q != 16'hFFFF) begin
                        wcnt_d = wcnt_q + 16'd1;
                    end
                end
            end
            ST_STROBE: begin
                state_d = ST_IDLE;
            end
            ST_FIN: begin
                state_d = ST_FIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready is registered from the next state so it is a pure state decode
        // as seen at the port, and is low in the cycle following a reset edge.
        ready_d = (state_d == ST_IDLE) || (state_d == ST_DATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bs_ready    = ready_q;
    assign config_data = data_q;
    assign config_en   = en_q;
    assign config_done = done_q;
    assign cfg_error   = err_q;
    assign write_count = wcnt_q;

endmodule
